// File: rtl/seq_det_scheduler_pkg.sv
// Shared types and defaults for the sequence-detector scheduler.
// Build option SEQ_DET_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
package seq_det_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_A = 2'd1,
    DRIVE_B = 2'd2,
    CHECK   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Requester-side bus of the scheduler: requests, stimulus pairs, grant and result.
interface seq_det_scheduler_if
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) ();

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  a_in;
  logic [NREQ-1:0]  b_in;
  logic [NREQ-1:0]  gnt;
  logic             done;
  logic             hit;
  logic [IDX_W-1:0] done_id;

  modport master (output req, a_in, b_in, input gnt, done, hit, done_id);
  modport slave  (input req, a_in, b_in, output gnt, done, hit, done_id);

endinterface

// File: rtl/seq_det.sv
// A-then-B Moore sequence detector: o_q is high for one state after A=1 then B=1.
module seq_det (
  input  logic clk,
  input  logic reset,
  input  logic i_a,
  input  logic i_b,
  output logic o_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_HIT   = 2'd2
  } det_state_t;

  det_state_t r_state;
  det_state_t w_state_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  if (i_a) w_state_nxt = S_GOT_A;
      S_GOT_A: begin
        if (i_b)      w_state_nxt = S_HIT;
        else if (i_a) w_state_nxt = S_GOT_A;
      end
      S_HIT:   if (i_a) w_state_nxt = S_GOT_A;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_q = (r_state == S_HIT);

endmodule

// File: rtl/seq_det_scheduler_rr_pick.sv
// Combinational arbiter: first asserted request searching upward from i_ptr, wrapping.
// With SEQ_DET_SCHED_FIXED_PRIO_EN the lowest asserted index wins and i_ptr is ignored.
module rr_pick #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_win_c,
  output logic             o_vld_c
);

  logic [IDX_W-1:0] w_idx;

`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`endif

  always_comb begin
    o_win_c = '0;
    o_vld_c = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
      w_idx = IDX_W'(k);
`else
      w_idx = IDX_W'((32'(i_ptr) + k) % NREQ);
`endif
      if (!o_vld_c && i_req[w_idx]) begin
        o_win_c = w_idx;
        o_vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shares one A-then-B detector among NREQ requesters, one 4-cycle transaction each.
// Build option SEQ_DET_SCHED_FIXED_PRIO_EN replaces round-robin with fixed priority.
module seq_det_scheduler
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  seq_det_scheduler_if.slave bus,
  output logic               o_det_a,
  output logic               o_det_b,
  input  logic               i_det_q,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_hit_count
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_id;
  logic             r_b;
  logic [NREQ-1:0]  r_gnt;
  logic             r_det_a;
  logic             r_det_b;
  logic             r_done;
  logic [IDX_W-1:0] r_done_id;
  logic [CNT_W-1:0] r_hit_count;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_win;
  logic             w_win_vld;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_ptr),
    .o_win_c (w_win),
    .o_vld_c (w_win_vld)
  );

`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  // Next search starts just past the requester that last completed.
  logic [IDX_W-1:0] r_rr_ptr;
  always_ff @(posedge clk) begin
    if (reset)                 r_rr_ptr <= '0;
    else if (r_state == CHECK) r_rr_ptr <= (r_id == IDX_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
  end
  assign w_ptr = r_rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_vld) w_state_nxt = DRIVE_A;
      DRIVE_A: w_state_nxt = DRIVE_B;
      DRIVE_B: w_state_nxt = CHECK;
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Detector drive and result strobes are loaded one edge ahead of the state that shows them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id        <= '0;
      r_b         <= 1'b0;
      r_gnt       <= '0;
      r_det_a     <= 1'b0;
      r_det_b     <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_hit_count <= '0;
    end else begin
      r_det_a   <= 1'b0;
      r_det_b   <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_id    <= w_win;
            r_b     <= bus.b_in[w_win];
            r_det_a <= bus.a_in[w_win];
            r_gnt   <= NREQ'(1) << w_win;
          end
        end
        DRIVE_A: r_det_b <= r_b;
        DRIVE_B: begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
        end
        CHECK: begin
          r_gnt <= '0;
          if (i_det_q && (r_hit_count != '1)) r_hit_count <= r_hit_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.hit     = (r_state == CHECK) && i_det_q;
  assign bus.done_id = r_done_id;
  assign o_det_a     = r_det_a;
  assign o_det_b     = r_det_b;
  assign o_busy      = (r_state != IDLE);
  assign o_hit_count = r_hit_count;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with the real seq_det as detector partner.
// Honours SEQ_DET_SCHED_FIXED_PRIO_EN in its arbitration model.
module tb_seq_det_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             det_a;
  logic             det_b;
  logic             det_q;
  logic             busy;
  logic [CNT_W-1:0] hit_count;

  int checks = 0;
  int errors = 0;
  int m_ptr;
  int m_cnt;

  seq_det_scheduler_if #(.NREQ(NREQ)) bus ();

  seq_det_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_det_a     (det_a),
    .o_det_b     (det_b),
    .i_det_q     (det_q),
    .o_busy      (busy),
    .o_hit_count (hit_count)
  );

  seq_det u_det (
    .clk   (clk),
    .reset (reset),
    .i_a   (det_a),
    .i_b   (det_b),
    .o_q   (det_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner the arbitration rules select, or -1 when nobody requests.
  function automatic int pick(input logic [3:0] rq, input int ptr);
    logic [3:0] sh;
    int         idx;
    pick = -1;
    for (int i = 0; i < int'(NREQ); i++) begin
`ifdef SEQ_DET_SCHED_FIXED_PRIO_EN
      idx = i;
`else
      idx = (ptr + i) % int'(NREQ);
`endif
      sh = rq >> idx;
      if (pick < 0 && sh[0]) pick = idx;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic run_txn(input logic [3:0] rq, input logic [3:0] av, input logic [3:0] bv,
                         input bit drop, input bit scramble);
    int         w;
    logic [3:0] t;
    logic       ea;
    logic       eb;
    bus.req  = rq;
    bus.a_in = av;
    bus.b_in = bv;
    w = pick(rq, m_ptr);
    @(negedge clk);
    if (w < 0) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      return;
    end
    t  = av >> w;
    ea = t[0];
    t  = bv >> w;
    eb = t[0];
    chk("c1_gnt", 32'(bus.gnt), 32'(4'b0001 << w));
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_det_a", 32'(det_a), 32'(ea));
    chk("c1_det_b", 32'(det_b), 32'd0);
    chk("c1_done", 32'(bus.done), 32'd0);
    chk("c1_det_q", 32'(det_q), 32'd0);
    if (drop) bus.req = bus.req & ~(4'b0001 << w);
    if (scramble) begin
      bus.a_in = 4'($urandom);
      bus.b_in = 4'($urandom);
    end
    @(negedge clk);
    chk("c2_gnt", 32'(bus.gnt), 32'(4'b0001 << w));
    chk("c2_det_a", 32'(det_a), 32'd0);
    chk("c2_det_b", 32'(det_b), 32'(eb));
    chk("c2_done", 32'(bus.done), 32'd0);
    chk("c2_det_q", 32'(det_q), 32'd0);
    @(negedge clk);
    chk("c3_gnt", 32'(bus.gnt), 32'(4'b0001 << w));
    chk("c3_det_ab", 32'({det_a, det_b}), 32'd0);
    chk("c3_done", 32'(bus.done), 32'd1);
    chk("c3_hit", 32'(bus.hit), 32'(ea & eb));
    chk("c3_done_id", 32'(bus.done_id), 32'(w));
    chk("c3_det_q", 32'(det_q), 32'(ea & eb));
    if (ea && eb && m_cnt < CNT_MAX) m_cnt++;
    m_ptr = (w + 1) % int'(NREQ);
    @(negedge clk);
    chk("c4_busy", 32'(busy), 32'd0);
    chk("c4_gnt", 32'(bus.gnt), 32'd0);
    chk("c4_done", 32'(bus.done), 32'd0);
    chk("c4_hit_count", 32'(hit_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
  endtask

  // Reset lands while DRIVE_B of a hitting transaction is on the detector.
  task automatic abort_in_drive_b();
    int w;
    bus.req  = 4'hF;
    bus.a_in = 4'hF;
    bus.b_in = 4'hF;
    w = pick(4'hF, m_ptr);
    @(negedge clk);
    chk("ab_gnt", 32'(bus.gnt), 32'(4'b0001 << w));
    @(negedge clk);
    chk("ab_det_b", 32'(det_b), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("ab_done", 32'(bus.done), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_gnt0", 32'(bus.gnt), 32'd0);
    chk("ab_hit_count", 32'(hit_count), 32'd0);
    reset   = 1'b0;
    bus.req = '0;
    m_ptr   = 0;
    m_cnt   = 0;
    @(negedge clk);
    chk("ab_done_after", 32'(bus.done), 32'd0);
    chk("ab_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    m_ptr    = 0;
    m_cnt    = 0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_det_ab", 32'({det_a, det_b}), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_hit", 32'(bus.hit), 32'd0);
    chk("reset_done_id", 32'(bus.done_id), 32'd0);
    chk("reset_hit_count", 32'(hit_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_txn(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("first_hit_count", 32'(hit_count), 32'd1);
    run_txn(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0);
    chk("miss_hit_count", 32'(hit_count), 32'd1);

    do_reset();
    repeat (5) run_txn(4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("all_req_hit_count", 32'(hit_count), 32'd5);

    abort_in_drive_b();
    run_txn(4'hF, 4'hF, 4'hF, 1'b0, 1'b0);

    run_txn(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
    run_txn(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_txn(4'($urandom), 4'($urandom), 4'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    do_reset();
    repeat (CNT_MAX + 3) run_txn(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("sat_hit_count", 32'(hit_count), 32'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
